data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder for the CPU core's memory-stage data port: serves the core's load/store requests (memread, memwrite, address, write data, 4-bit byte-lane select) and returns read data.
- Backs requests with an internal byte-enabled word RAM plus a small memory-mapped register window (LED output, free-running timer, store counter).
- Sits beside the core at SoC top level and replaces the bare behavioural data RAM.
- Read data is registered, so load data is valid in the cycle after the request.

Parameters:
- ADDR_W, 10, word-address width of the internal RAM (depth = 2^ADDR_W words).
- MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the register window.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- memread  in  1  load request this cycle
- memwrite  in  1  store request this cycle
- addr  in  32  byte address; bits [1:0] ignored, lanes come from sel
- wdata  in  32  store data, already lane-aligned
- sel  in  4  byte-lane enables; sel[i] covers wdata[8i+7:8i]
- rdata  out  32  registered load data
- led  out  32  LED register contents
- bad_addr  out  1  sticky flag: access to an unmapped address

Behaviour:
- Reset: clk single clock; rst synchronous, active-high. On reset: rdata=0, led=0, timer=0, stcnt=0, bad_addr=0. RAM contents are not reset.
- Decode: window when addr[31:16]==MMIO_HI; otherwise RAM.
  - RAM physical address = addr & 32'h1FFF_FFFF; word index = phys[ADDR_W+1:2].
  - RAM access is in range iff phys < 4*2^ADDR_W.
- Window offsets are addr[15:0]:
  - 0x0000 LED, read/write.
  - 0x0004 TIMER, read/write.
  - 0x0008 STCNT, read-only; writes are ignored and are not an error.
  - Any other offset is unmapped.
- Read: when memread=1 at a rising edge, rdata takes the full 32-bit word at the decoded location. sel does not mask reads. rdata holds its value in every cycle where memread=0. Latency is exactly 1 cycle.
- Write: when memwrite=1 at a rising edge, each lane with sel[i]=1 takes wdata lane i; other lanes keep their value. sel=4'b0000 is a no-op and does not count.
- memread and memwrite together on the same address: read-before-write. rdata gets the old word and the store still lands.
- TIMER:
  - Increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - A store to TIMER replaces the selected bytes with wdata and suppresses that cycle's increment.
  - Unselected bytes take the value they would have had without the store, i.e. the incremented value.
- STCNT: +1 for each RAM store with sel!=0 that is in range. Saturates at 32'hFFFF_FFFF.
- Unmapped access (RAM out of range, or unmapped window offset), with memread or memwrite high:
  - bad_addr is set at that edge and stays set until rst.
  - A read returns rdata=0.
  - A write has no effect.
- Idle cycles (memread=memwrite=0) have no side effects except the timer increment.
- Reset mid-operation: rst takes priority over any concurrent request in the same cycle. That request is dropped: no RAM write, no counter update.

Decomposition:
- Shared package holds:
  - the window offset constants LED_OFF, TIMER_OFF, STCNT_OFF;
  - MMIO_HI default;
  - the physical-address mask 32'h1FFF_FFFF.
- One sub-module, bram_be: single-port, byte-enabled synchronous RAM.
  - Parameter: ADDR_W.
  - Ports: clk, we[3:0], a, d, q.
  - Read-before-write; q registered.
- The top level holds decode, the window registers, the rdata mux, and the error flag.

Test Plan:
- Store 32'hDEAD_BEEF, sel=1111 to addr 0x0000_0010. Then load 0x0000_0010 -> rdata=32'hDEAD_BEEF one cycle after the load. STCNT reads 1.
- Store 32'h0000_00AA, sel=0001 to 0x10, then load 0x10 -> rdata=32'hDEAD_BEAA. Store with sel=0000 -> word unchanged, STCNT unchanged.
- memread and memwrite together on 0x10 with wdata=32'h1234_5678, sel=1111 -> rdata=32'hDEAD_BEAA. The next load of 0x10 returns 32'h1234_5678.
- Store 32'hFFFF_FFFE to 0xBFAF_0004 (TIMER), idle 1 cycle, then load TIMER -> rdata=32'h0000_0000, proving the wrap. Store 32'h0000_00F0 to 0xBFAF_0000 -> led=32'h0000_00F0 on the next cycle.
- Load 0x0000_1000 with ADDR_W=10 (out of range) -> rdata=0, bad_addr=1. bad_addr stays 1 through later legal accesses until rst.
- Assert rst in the same cycle as a store to 0x20 -> led=0, timer=0, STCNT=0, bad_addr=0, and the word at 0x20 is not modified.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared constants and helpers for the data-port responder: register window
// offsets, physical-address mask and the byte-lane merge used by window registers.
package data_mem_responder_pkg;

  localparam logic [15:0] LED_OFF     = 16'h0000;
  localparam logic [15:0] TIMER_OFF   = 16'h0004;
  localparam logic [15:0] STCNT_OFF   = 16'h0008;
  localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;
  localparam logic [31:0] PHYS_MASK   = 32'h1FFF_FFFF;

  typedef enum logic [2:0] {
    TGT_RAM   = 3'd0,
    TGT_LED   = 3'd1,
    TGT_TIMER = 3'd2,
    TGT_STCNT = 3'd3,
    TGT_BAD   = 3'd4
  } target_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_responder_bram_be.sv
// Single-port byte-enabled word RAM with registered, read-before-write output.
module bram_be #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       d,
  output logic [31:0]       q
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];

  // q always sees the pre-write word, giving read-before-write on a shared address
  always_ff @(posedge clk) begin
    q <= mem_q[a];
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_q[a][8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data port responder: byte-enabled RAM plus LED/TIMER/STCNT
// register window, registered load data and a sticky unmapped-access flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  sel,
  output logic [31:0] rdata,
  output logic [31:0] led,
  output logic        bad_addr
);

  logic [31:0]       phys_s;
  target_e           target_s;
  logic [3:0]        ram_we_s;
  logic [ADDR_W-1:0] ram_a_s;
  logic [31:0]       ram_q_s;
  logic [31:0]       rdata_s;
  logic [31:0]       timer_inc_s;

  logic [31:0] led_q,   led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] stcnt_q, stcnt_d;
  logic        bad_q,   bad_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ram_rd_q, ram_rd_d;

  // Address decode: register window first, then RAM range check on the masked address
  always_comb begin
    phys_s   = addr & PHYS_MASK;
    target_s = TGT_BAD;
    if (addr[31:16] == MMIO_HI) begin
      case (addr[15:0])
        LED_OFF:   target_s = TGT_LED;
        TIMER_OFF: target_s = TGT_TIMER;
        STCNT_OFF: target_s = TGT_STCNT;
        default:   target_s = TGT_BAD;
      endcase
    end else if (phys_s[31:ADDR_W+2] == '0) begin
      target_s = TGT_RAM;
    end else begin
      target_s = TGT_BAD;
    end
  end

  // Reset drops any concurrent store so the RAM is never written during rst
  assign ram_we_s = (!rst && memwrite && (target_s == TGT_RAM)) ? sel : 4'b0000;
  assign ram_a_s  = phys_s[ADDR_W+1:2];

  bram_be #(.ADDR_W(ADDR_W)) u_bram (
    .clk (clk),
    .we  (ram_we_s),
    .a   (ram_a_s),
    .d   (wdata),
    .q   (ram_q_s)
  );

  // RAM data is only live the cycle after a RAM load; otherwise the held value shows
  assign rdata_s     = ram_rd_q ? ram_q_s : rdata_q;
  assign timer_inc_s = timer_q + 32'd1;

  always_comb begin
    led_d    = led_q;
    timer_d  = timer_inc_s;
    stcnt_d  = stcnt_q;
    bad_d    = bad_q;
    rdata_d  = rdata_s;
    ram_rd_d = 1'b0;

    if (memread) begin
      case (target_s)
        TGT_RAM:   ram_rd_d = 1'b1;
        TGT_LED:   rdata_d  = led_q;
        TGT_TIMER: rdata_d  = timer_inc_s;
        TGT_STCNT: rdata_d  = stcnt_q;
        default:   rdata_d  = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = rdata_s;
    end

    if (memwrite) begin
      case (target_s)
        TGT_RAM: begin
          if ((sel != 4'b0000) && (stcnt_q != 32'hFFFF_FFFF)) begin
            stcnt_d = stcnt_q + 32'd1;
          end else begin
            stcnt_d = stcnt_q;
          end
        end
        TGT_LED:   led_d   = lane_merge(led_q, wdata, sel);
        TGT_TIMER: timer_d = lane_merge(timer_inc_s, wdata, sel);
        TGT_STCNT: stcnt_d = stcnt_q;
        default:   bad_d   = 1'b1;
      endcase
    end else begin
      stcnt_d = stcnt_q;
    end

    if ((memread || memwrite) && (target_s == TGT_BAD)) begin
      bad_d = 1'b1;
    end else begin
      bad_d = bad_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= 32'h0000_0000;
      timer_q  <= 32'h0000_0000;
      stcnt_q  <= 32'h0000_0000;
      bad_q    <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      ram_rd_q <= 1'b0;
    end else begin
      led_q    <= led_d;
      timer_q  <= timer_d;
      stcnt_q  <= stcnt_d;
      bad_q    <= bad_d;
      rdata_q  <= rdata_d;
      ram_rd_q <= ram_rd_d;
    end
  end

  assign rdata    = rdata_s;
  assign led      = led_q;
  assign bad_addr = bad_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: load expectations go into a queue when the
// load is driven and are checked against rdata the cycle after.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [31:0] rdata;
  logic [31:0] led;
  logic        bad_addr;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  localparam logic [31:0] A_LED   = 32'hBFAF_0000;
  localparam logic [31:0] A_TIMER = 32'hBFAF_0004;
  localparam logic [31:0] A_STCNT = 32'hBFAF_0008;

  data_mem_responder #(.ADDR_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .memread  (memread),
    .memwrite (memwrite),
    .addr     (addr),
    .wdata    (wdata),
    .sel      (sel),
    .rdata    (rdata),
    .led      (led),
    .bad_addr (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus; a load pushes its expectation and is checked after the edge
  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s, input logic r,
                      input logic [31:0] exp, input string tag);
    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = wd;
    sel      = s;
    rst      = r;
    if (rd && !r) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    memread  = 1'b0;
    memwrite = 1'b0;
    rst      = 1'b0;
    if (exp_q.size() != 0) begin
      check(tag_q.pop_front(), rdata, exp_q.pop_front());
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    step(1'b0, 1'b1, a, wd, s, 1'b0, 32'h0, "");
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
    step(1'b1, 1'b0, a, 32'h0, 4'b0000, 1'b0, exp, tag);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, "");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    memread  = 1'b0;
    memwrite = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    sel      = 4'b0000;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", led, 32'h0);
    check("reset_bad", {31'h0, bad_addr}, 32'h0);

    // full-word store and load, store counter
    store(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    load(32'h0000_0010, 32'hDEAD_BEEF, "load_full");
    load(A_STCNT, 32'h1, "stcnt_1");

    // partial lanes and empty sel
    store(32'h0000_0010, 32'h0000_00AA, 4'b0001);
    load(32'h0000_0010, 32'hDEAD_BEAA, "load_lane0");
    store(32'h0000_0010, 32'hFFFF_FFFF, 4'b0000);
    load(32'h0000_0010, 32'hDEAD_BEAA, "sel0_noop");
    load(A_STCNT, 32'h2, "stcnt_sel0");
    idle();
    check("rdata_hold_mmio", rdata, 32'h2);

    // simultaneous read and write: old data returned, new data stored
    step(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 1'b0, 32'hDEAD_BEAA, "rbw_old");
    load(32'h0000_0010, 32'h1234_5678, "rbw_new");
    idle();
    check("rdata_hold_ram", rdata, 32'h1234_5678);
    load(A_STCNT, 32'h3, "stcnt_3");

    // timer wrap and LED register
    store(A_TIMER, 32'hFFFF_FFFE, 4'b1111);
    idle();
    load(A_TIMER, 32'h0, "timer_wrap");
    store(A_LED, 32'h0000_00F0, 4'b1111);
    check("led_out", led, 32'h0000_00F0);
    store(A_LED, 32'h0000_5500, 4'b0010);
    load(A_LED, 32'h0000_55F0, "led_lane1");
    store(A_STCNT, 32'hAAAA_AAAA, 4'b1111);
    load(A_STCNT, 32'h3, "stcnt_ro");
    check("bad_clear", {31'h0, bad_addr}, 32'h0);
    load(32'h2000_0010, 32'h1234_5678, "phys_alias");

    // out-of-range accesses
    load(32'h0000_1000, 32'h0, "oor_load");
    check("bad_set", {31'h0, bad_addr}, 32'h1);
    store(32'h0000_1010, 32'h0, 4'b1111);
    load(32'h0000_0010, 32'h1234_5678, "oor_no_write");
    load(32'hBFAF_000C, 32'h0, "win_unmapped");
    load(A_STCNT, 32'h3, "stcnt_oor");
    check("bad_sticky", {31'h0, bad_addr}, 32'h1);

    // reset concurrent with a store: the store is dropped
    store(32'h0000_0020, 32'hCAFE_F00D, 4'b1111);
    load(A_STCNT, 32'h4, "stcnt_4");
    step(1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 4'b1111, 1'b1, 32'h0, "");
    check("rst_led", led, 32'h0);
    check("rst_bad", {31'h0, bad_addr}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    load(A_TIMER, 32'h1, "rst_timer");
    load(A_STCNT, 32'h0, "rst_stcnt");
    load(32'h0000_0020, 32'hCAFE_F00D, "rst_drop_store");

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
